// File: rtl/wb_commit.sv
// wb_commit: dual-issue in-order writeback/commit stage with a sid-indexed completion buffer.
// Optional feature macro WB_ENDSIM_EN: an end-of-simulation marker halts retirement and raises sticky endsim_o.
module wb_commit #(
    parameter int SID_W = 3,
    parameter int XLEN  = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cpl0_valid_i,
    input  logic [SID_W:0]  cpl0_sid_i,
    input  logic [1:0]      cpl0_rd_type_i,
    input  logic [4:0]      cpl0_rd_i,
    input  logic [XLEN-1:0] cpl0_value_i,
    input  logic            cpl0_flush_i,
    input  logic            cpl0_endsim_i,
    input  logic            cpl1_valid_i,
    input  logic [SID_W:0]  cpl1_sid_i,
    input  logic [1:0]      cpl1_rd_type_i,
    input  logic [4:0]      cpl1_rd_i,
    input  logic [XLEN-1:0] cpl1_value_i,
    input  logic            cpl1_flush_i,
    input  logic            cpl1_endsim_i,
    output logic            inst0_wb_valid_o,
    output logic [4:0]      inst0_wb_rd_o,
    output logic [XLEN-1:0] inst0_wb_value_o,
    output logic            inst0_retire_valid_o,
    output logic [SID_W:0]  inst0_retire_sid_o,
    output logic            inst1_wb_valid_o,
    output logic [4:0]      inst1_wb_rd_o,
    output logic [XLEN-1:0] inst1_wb_value_o,
    output logic            inst1_retire_valid_o,
    output logic [SID_W:0]  inst1_retire_sid_o,
    output logic            flush_operands_o,
    output logic            endsim_o,
    output logic            err_o
);
    localparam int DEPTH = 1 << SID_W;
    localparam logic [SID_W:0] SID_ONE = (SID_W + 1)'(1);
    localparam logic [SID_W:0] SID_TWO = (SID_W + 1)'(2);

    logic [DEPTH-1:0] slot_rdy;
    logic [DEPTH-1:0] slot_rdy_nxt;
    logic [DEPTH-1:0] slot_flush;
    logic [1:0]       slot_rd_type [DEPTH];
    logic [4:0]       slot_rd      [DEPTH];
    logic [XLEN-1:0]  slot_value   [DEPTH];

    logic [SID_W:0]   head_sid;
    logic [SID_W:0]   head1_sid;
    logic [SID_W-1:0] h0_idx;
    logic [SID_W-1:0] h1_idx;
    logic [SID_W-1:0] c0_idx;
    logic [SID_W-1:0] c1_idx;
    logic [SID_W:0]   c0_dist;
    logic [SID_W:0]   c1_dist;
    logic             halt;
    logic             stop0;
    logic             ret0;
    logic             ret1;
    logic             flush_now;
    logic             acc0;
    logic             acc1;
    logic             same_sid;
    logic             bad0;
    logic             bad1;
    logic             wr0;
    logic             wr1;

    assign head1_sid = head_sid + SID_ONE;
    assign h0_idx    = head_sid[SID_W-1:0];
    assign h1_idx    = head1_sid[SID_W-1:0];

`ifdef WB_ENDSIM_EN
    logic [DEPTH-1:0] slot_endsim;
    logic             endsim_now;

    assign halt       = endsim_o;
    assign stop0      = slot_endsim[h0_idx];
    assign endsim_now = (ret0 & slot_endsim[h0_idx]) | (ret1 & slot_endsim[h1_idx]);
`else
    logic unused_endsim;

    assign halt          = 1'b0;
    assign stop0         = 1'b0;
    assign unused_endsim = cpl0_endsim_i | cpl1_endsim_i;
    assign endsim_o      = 1'b0;
`endif

    // inst1 may only follow an inst0 that neither redirects nor ends the run
    assign ret0      = slot_rdy[h0_idx] & ~halt;
    assign ret1      = ret0 & slot_rdy[h1_idx] & ~slot_flush[h0_idx] & ~stop0;
    assign flush_now = (ret0 & slot_flush[h0_idx]) | (ret1 & slot_flush[h1_idx]);

    // window test: distance from head must be below DEPTH, i.e. the distance MSB is clear
    assign c0_idx   = cpl0_sid_i[SID_W-1:0];
    assign c1_idx   = cpl1_sid_i[SID_W-1:0];
    assign c0_dist  = cpl0_sid_i - head_sid;
    assign c1_dist  = cpl1_sid_i - head_sid;
    assign acc0     = cpl0_valid_i & ~flush_operands_o;
    assign acc1     = cpl1_valid_i & ~flush_operands_o;
    assign same_sid = acc0 & acc1 & (cpl0_sid_i == cpl1_sid_i);
    assign bad0     = acc0 & (c0_dist[SID_W] | slot_rdy[c0_idx] | same_sid);
    assign bad1     = acc1 & (c1_dist[SID_W] | slot_rdy[c1_idx] | same_sid);
    assign wr0      = acc0 & ~bad0;
    assign wr1      = acc1 & ~bad1;

    always_comb begin
        slot_rdy_nxt = slot_rdy;
        if (flush_now) begin
            slot_rdy_nxt = '0;
        end else begin
            if (ret0) slot_rdy_nxt[h0_idx] = 1'b0;
            if (ret1) slot_rdy_nxt[h1_idx] = 1'b0;
            if (wr0)  slot_rdy_nxt[c0_idx] = 1'b1;
            if (wr1)  slot_rdy_nxt[c1_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr0) begin
            slot_rd_type[c0_idx] <= cpl0_rd_type_i;
            slot_rd[c0_idx]      <= cpl0_rd_i;
            slot_value[c0_idx]   <= cpl0_value_i;
            slot_flush[c0_idx]   <= cpl0_flush_i;
`ifdef WB_ENDSIM_EN
            slot_endsim[c0_idx]  <= cpl0_endsim_i;
`endif
        end
        if (wr1) begin
            slot_rd_type[c1_idx] <= cpl1_rd_type_i;
            slot_rd[c1_idx]      <= cpl1_rd_i;
            slot_value[c1_idx]   <= cpl1_value_i;
            slot_flush[c1_idx]   <= cpl1_flush_i;
`ifdef WB_ENDSIM_EN
            slot_endsim[c1_idx]  <= cpl1_endsim_i;
`endif
        end
    end

    // a flushing entry is always the last retired, so head + count equals flushing sid + 1
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_rdy             <= '0;
            head_sid             <= '0;
            inst0_wb_valid_o     <= 1'b0;
            inst0_wb_rd_o        <= '0;
            inst0_wb_value_o     <= '0;
            inst0_retire_valid_o <= 1'b0;
            inst0_retire_sid_o   <= '0;
            inst1_wb_valid_o     <= 1'b0;
            inst1_wb_rd_o        <= '0;
            inst1_wb_value_o     <= '0;
            inst1_retire_valid_o <= 1'b0;
            inst1_retire_sid_o   <= '0;
            flush_operands_o     <= 1'b0;
            err_o                <= 1'b0;
        end else begin
            slot_rdy             <= slot_rdy_nxt;
            head_sid             <= ret1 ? head_sid + SID_TWO : (ret0 ? head1_sid : head_sid);
            inst0_wb_valid_o     <= ret0 & (slot_rd_type[h0_idx] == 2'b01) & (slot_rd[h0_idx] != 5'd0);
            inst0_wb_rd_o        <= ret0 ? slot_rd[h0_idx] : '0;
            inst0_wb_value_o     <= ret0 ? slot_value[h0_idx] : '0;
            inst0_retire_valid_o <= ret0;
            inst0_retire_sid_o   <= ret0 ? head_sid : '0;
            inst1_wb_valid_o     <= ret1 & (slot_rd_type[h1_idx] == 2'b01) & (slot_rd[h1_idx] != 5'd0);
            inst1_wb_rd_o        <= ret1 ? slot_rd[h1_idx] : '0;
            inst1_wb_value_o     <= ret1 ? slot_value[h1_idx] : '0;
            inst1_retire_valid_o <= ret1;
            inst1_retire_sid_o   <= ret1 ? head1_sid : '0;
            flush_operands_o     <= flush_now;
            err_o                <= err_o | bad0 | bad1;
        end
    end

`ifdef WB_ENDSIM_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            endsim_o <= 1'b0;
        end else begin
            endsim_o <= endsim_o | endsim_now;
        end
    end
`endif

endmodule

// File: tb/tb_wb_commit.sv
// Testbench for wb_commit: directed scenarios plus randomized completions against a sid-keyed reference model.
module tb_wb_commit;
    localparam int NSID = 16;
    localparam int WIN  = 8;
`ifdef WB_ENDSIM_EN
    localparam bit ENDSIM = 1'b1;
`else
    localparam bit ENDSIM = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        cpl0_valid_i, cpl1_valid_i;
    logic [3:0]  cpl0_sid_i, cpl1_sid_i;
    logic [1:0]  cpl0_rd_type_i, cpl1_rd_type_i;
    logic [4:0]  cpl0_rd_i, cpl1_rd_i;
    logic [63:0] cpl0_value_i, cpl1_value_i;
    logic        cpl0_flush_i, cpl1_flush_i;
    logic        cpl0_endsim_i, cpl1_endsim_i;
    logic        inst0_wb_valid_o, inst1_wb_valid_o;
    logic [4:0]  inst0_wb_rd_o, inst1_wb_rd_o;
    logic [63:0] inst0_wb_value_o, inst1_wb_value_o;
    logic        inst0_retire_valid_o, inst1_retire_valid_o;
    logic [3:0]  inst0_retire_sid_o, inst1_retire_sid_o;
    logic        flush_operands_o, endsim_o, err_o;

    wb_commit #(.SID_W(3), .XLEN(64)) dut (
        .clk(clk), .rst(rst),
        .cpl0_valid_i(cpl0_valid_i), .cpl0_sid_i(cpl0_sid_i), .cpl0_rd_type_i(cpl0_rd_type_i),
        .cpl0_rd_i(cpl0_rd_i), .cpl0_value_i(cpl0_value_i), .cpl0_flush_i(cpl0_flush_i),
        .cpl0_endsim_i(cpl0_endsim_i),
        .cpl1_valid_i(cpl1_valid_i), .cpl1_sid_i(cpl1_sid_i), .cpl1_rd_type_i(cpl1_rd_type_i),
        .cpl1_rd_i(cpl1_rd_i), .cpl1_value_i(cpl1_value_i), .cpl1_flush_i(cpl1_flush_i),
        .cpl1_endsim_i(cpl1_endsim_i),
        .inst0_wb_valid_o(inst0_wb_valid_o), .inst0_wb_rd_o(inst0_wb_rd_o),
        .inst0_wb_value_o(inst0_wb_value_o), .inst0_retire_valid_o(inst0_retire_valid_o),
        .inst0_retire_sid_o(inst0_retire_sid_o),
        .inst1_wb_valid_o(inst1_wb_valid_o), .inst1_wb_rd_o(inst1_wb_rd_o),
        .inst1_wb_value_o(inst1_wb_value_o), .inst1_retire_valid_o(inst1_retire_valid_o),
        .inst1_retire_sid_o(inst1_retire_sid_o),
        .flush_operands_o(flush_operands_o), .endsim_o(endsim_o), .err_o(err_o)
    );

    initial forever #5 clk = ~clk;

    // reference model: completed work keyed by full sid, program-order head pointer
    bit        m_done [NSID];
    bit [1:0]  m_type [NSID];
    bit [4:0]  m_rd   [NSID];
    bit [63:0] m_val  [NSID];
    bit        m_fl   [NSID];
    bit        m_es   [NSID];
    int        m_head;
    bit        m_pulse, m_halt, m_err;
    bit        e_rv [2];
    bit [3:0]  e_sid[2];
    bit        e_wv [2];
    bit [4:0]  e_rd [2];
    bit [63:0] e_val[2];

    int n_cmp;
    int n_bad;

    task automatic model_reset();
        for (int i = 0; i < NSID; i++) begin
            m_done[i] = 0; m_type[i] = 0; m_rd[i] = 0; m_val[i] = 0; m_fl[i] = 0; m_es[i] = 0;
        end
        for (int k = 0; k < 2; k++) begin
            e_rv[k] = 0; e_sid[k] = 0; e_wv[k] = 0; e_rd[k] = 0; e_val[k] = 0;
        end
        m_head = 0; m_pulse = 0; m_halt = 0; m_err = 0;
    endtask

    task automatic model_edge();
        int  n, s, off0, off1;
        bit  fl, es, acc0, acc1, bad0, bad1;
        n = 0; fl = 0; es = 0;
        for (int k = 0; k < 2; k++) begin
            e_rv[k] = 0; e_sid[k] = 0; e_wv[k] = 0; e_rd[k] = 0; e_val[k] = 0;
        end
        if (!m_halt) begin
            for (int k = 0; k < 2; k++) begin
                s = (m_head + k) % NSID;
                if (!m_done[s]) break;
                e_rv[k]  = 1;
                e_sid[k] = 4'(s);
                e_rd[k]  = m_rd[s];
                e_val[k] = m_val[s];
                e_wv[k]  = (m_type[s] == 2'b01) && (m_rd[s] != 0);
                n++;
                if (m_fl[s]) begin fl = 1; break; end
                if (ENDSIM && m_es[s]) begin es = 1; break; end
            end
        end
        acc0 = cpl0_valid_i && !m_pulse;
        acc1 = cpl1_valid_i && !m_pulse;
        off0 = (int'(cpl0_sid_i) - m_head + NSID) % NSID;
        off1 = (int'(cpl1_sid_i) - m_head + NSID) % NSID;
        bad0 = acc0 && (off0 >= WIN || m_done[cpl0_sid_i] || (acc1 && cpl0_sid_i == cpl1_sid_i));
        bad1 = acc1 && (off1 >= WIN || m_done[cpl1_sid_i] || (acc0 && cpl0_sid_i == cpl1_sid_i));
        for (int k = 0; k < n; k++) m_done[(m_head + k) % NSID] = 0;
        if (acc0 && !bad0) begin
            m_done[cpl0_sid_i] = 1; m_type[cpl0_sid_i] = cpl0_rd_type_i; m_rd[cpl0_sid_i] = cpl0_rd_i;
            m_val[cpl0_sid_i] = cpl0_value_i; m_fl[cpl0_sid_i] = cpl0_flush_i; m_es[cpl0_sid_i] = cpl0_endsim_i;
        end
        if (acc1 && !bad1) begin
            m_done[cpl1_sid_i] = 1; m_type[cpl1_sid_i] = cpl1_rd_type_i; m_rd[cpl1_sid_i] = cpl1_rd_i;
            m_val[cpl1_sid_i] = cpl1_value_i; m_fl[cpl1_sid_i] = cpl1_flush_i; m_es[cpl1_sid_i] = cpl1_endsim_i;
        end
        m_head = (m_head + n) % NSID;
        if (fl) for (int i = 0; i < NSID; i++) m_done[i] = 0;
        m_pulse = fl;
        m_err   = m_err | bad0 | bad1;
        m_halt  = m_halt | es;
    endtask

    function automatic logic [152:0] dut_vec();
        return {inst0_wb_valid_o, inst0_wb_rd_o, inst0_wb_value_o, inst0_retire_valid_o, inst0_retire_sid_o,
                inst1_wb_valid_o, inst1_wb_rd_o, inst1_wb_value_o, inst1_retire_valid_o, inst1_retire_sid_o,
                flush_operands_o, endsim_o, err_o};
    endfunction

    function automatic logic [152:0] exp_vec();
        return {e_wv[0], e_rd[0], e_val[0], e_rv[0], e_sid[0],
                e_wv[1], e_rd[1], e_val[1], e_rv[1], e_sid[1],
                m_pulse, m_halt, m_err};
    endfunction

    task automatic clear_inputs();
        cpl0_valid_i = 0; cpl0_sid_i = 0; cpl0_rd_type_i = 0; cpl0_rd_i = 0; cpl0_value_i = 0;
        cpl0_flush_i = 0; cpl0_endsim_i = 0;
        cpl1_valid_i = 0; cpl1_sid_i = 0; cpl1_rd_type_i = 0; cpl1_rd_i = 0; cpl1_value_i = 0;
        cpl1_flush_i = 0; cpl1_endsim_i = 0;
    endtask

    task automatic drive(input int port, input int sid, input bit [1:0] typ, input bit [4:0] rd,
                         input bit [63:0] val, input bit fl, input bit es);
        if (port == 0) begin
            cpl0_valid_i = 1; cpl0_sid_i = 4'(sid); cpl0_rd_type_i = typ; cpl0_rd_i = rd;
            cpl0_value_i = val; cpl0_flush_i = fl; cpl0_endsim_i = es;
        end else begin
            cpl1_valid_i = 1; cpl1_sid_i = 4'(sid); cpl1_rd_type_i = typ; cpl1_rd_i = rd;
            cpl1_value_i = val; cpl1_flush_i = fl; cpl1_endsim_i = es;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        clear_inputs();
    endtask

    task automatic do_reset();
        rst = 1;
        clear_inputs();
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_cmp++;
        if (dut_vec() !== 153'd0) begin
            n_bad++; $display("FAIL reset_idle got=%h exp=0", dut_vec());
        end
        rst = 0;
        drive(0, 0, 2'b01, 3, 64'h11, 0, 0);
        drive(1, 1, 2'b01, 4, 64'h22, 0, 0);
        step();
        step();
        n_cmp++;
        if (dut_vec() !== exp_vec()) begin
            n_bad++; $display("FAIL reset_pre got=%h exp=%h", dut_vec(), exp_vec());
        end
        rst = 1;
        #1;
        n_cmp++;
        if (dut_vec() !== 153'd0) begin
            n_bad++; $display("FAIL reset_async got=%h exp=0", dut_vec());
        end
        model_reset();
        @(negedge clk);
        rst = 0;
    endtask

    task automatic test_single();
        do_reset();
        for (int c = 0; c < 4; c++) begin
            if (c == 0) drive(0, 0, 2'b01, 5, 64'hDEAD, 0, 0);
            step();
            n_cmp++;
            if (dut_vec() !== exp_vec()) begin
                n_bad++; $display("FAIL single_model cyc%0d got=%h exp=%h", c, dut_vec(), exp_vec());
            end
            n_cmp++;
            if ({inst0_wb_valid_o, inst0_wb_rd_o, inst0_wb_value_o, inst0_retire_sid_o} !==
                ((c == 1) ? {1'b1, 5'd5, 64'hDEAD, 4'd0} : {1'b0, 5'd0, 64'd0, 4'd0})) begin
                n_bad++; $display("FAIL single_out cyc%0d got=%b/%0d/%h/%0d", c, inst0_wb_valid_o,
                                  inst0_wb_rd_o, inst0_wb_value_o, inst0_retire_sid_o);
            end
        end
    endtask

    task automatic test_out_of_order();
        int first_ret;
        first_ret = -1;
        do_reset();
        for (int c = 0; c < 8; c++) begin
            if (c == 0) drive(0, 1, 2'b01, 7, 64'h71, 0, 0);
            if (c == 3) drive(1, 0, 2'b01, 6, 64'h60, 0, 0);
            step();
            n_cmp++;
            if (dut_vec() !== exp_vec()) begin
                n_bad++; $display("FAIL ooo_model cyc%0d got=%h exp=%h", c, dut_vec(), exp_vec());
            end
            if (first_ret < 0 && inst0_retire_valid_o) begin
                first_ret = c;
                n_cmp++;
                if ({inst0_retire_sid_o, inst1_retire_valid_o, inst1_retire_sid_o} !== {4'd0, 1'b1, 4'd1}) begin
                    n_bad++; $display("FAIL ooo_pair got sid0=%0d v1=%b sid1=%0d exp 0/1/1",
                                      inst0_retire_sid_o, inst1_retire_valid_o, inst1_retire_sid_o);
                end
            end
        end
        n_cmp++;
        if (first_ret != 4) begin
            n_bad++; $display("FAIL ooo_latency got=%0d exp=4", first_ret);
        end
    endtask

    task automatic test_x0_nodest();
        do_reset();
        for (int c = 0; c < 3; c++) begin
            if (c == 0) begin
                drive(0, 0, 2'b01, 0, 64'hA0, 0, 0);
                drive(1, 1, 2'b00, 7, 64'hA1, 0, 0);
            end
            step();
            n_cmp++;
            if (dut_vec() !== exp_vec()) begin
                n_bad++; $display("FAIL x0_model cyc%0d got=%h exp=%h", c, dut_vec(), exp_vec());
            end
            if (c == 1) begin
                n_cmp++;
                if ({inst0_retire_valid_o, inst1_retire_valid_o, inst0_wb_valid_o, inst1_wb_valid_o} !== 4'b1100) begin
                    n_bad++; $display("FAIL x0_flags got=%b%b%b%b exp=1100", inst0_retire_valid_o,
                                      inst1_retire_valid_o, inst0_wb_valid_o, inst1_wb_valid_o);
                end
            end
        end
    endtask

    task automatic test_flush();
        do_reset();
        for (int c = 0; c < 8; c++) begin
            case (c)
                0: begin drive(0, 1, 2'b01, 1, 64'hF1, 0, 0); drive(1, 2, 2'b01, 2, 64'hF2, 0, 0); end
                1: drive(0, 0, 2'b01, 3, 64'hF0, 1, 0);
                3: drive(0, 3, 2'b01, 4, 64'hF3, 0, 0);
                4: drive(0, 1, 2'b01, 9, 64'hB1, 0, 0);
                default: ;
            endcase
            step();
            n_cmp++;
            if (dut_vec() !== exp_vec()) begin
                n_bad++; $display("FAIL flush_model cyc%0d got=%h exp=%h", c, dut_vec(), exp_vec());
            end
            if (c == 2) begin
                n_cmp++;
                if ({inst0_retire_valid_o, inst0_retire_sid_o, inst1_retire_valid_o, flush_operands_o} !== {1'b1, 4'd0, 1'b0, 1'b1}) begin
                    n_bad++; $display("FAIL flush_edge got v0=%b sid0=%0d v1=%b fl=%b exp 1/0/0/1",
                                      inst0_retire_valid_o, inst0_retire_sid_o, inst1_retire_valid_o, flush_operands_o);
                end
            end
            if (c == 3) begin
                n_cmp++;
                if ({flush_operands_o, err_o, inst0_retire_valid_o} !== 3'b000) begin
                    n_bad++; $display("FAIL flush_pulse got fl=%b err=%b v0=%b exp 000",
                                      flush_operands_o, err_o, inst0_retire_valid_o);
                end
            end
            if (c == 5) begin
                n_cmp++;
                if ({inst0_retire_valid_o, inst0_retire_sid_o, inst1_retire_valid_o} !== {1'b1, 4'd1, 1'b0}) begin
                    n_bad++; $display("FAIL flush_head got v0=%b sid0=%0d v1=%b exp 1/1/0",
                                      inst0_retire_valid_o, inst0_retire_sid_o, inst1_retire_valid_o);
                end
            end
        end
    endtask

    task automatic test_wrap();
        int got0[$];
        do_reset();
        for (int c = 0; c < 11; c++) begin
            if (c < 9) begin
                drive(0, (2 * c) % NSID, 2'b01, 5'(c + 1), 64'(c), 0, 0);
                drive(1, (2 * c + 1) % NSID, 2'b01, 5'(c + 10), 64'(c + 100), 0, 0);
            end
            step();
            n_cmp++;
            if (dut_vec() !== exp_vec()) begin
                n_bad++; $display("FAIL wrap_model cyc%0d got=%h exp=%h", c, dut_vec(), exp_vec());
            end
            if (inst0_retire_valid_o) got0.push_back(int'(inst0_retire_sid_o));
        end
        n_cmp++;
        if (got0.size() != 9) begin
            n_bad++; $display("FAIL wrap_count got=%0d exp=9", got0.size());
        end else begin
            for (int i = 0; i < 9; i++) begin
                n_cmp++;
                if (got0[i] != (2 * i) % NSID) begin
                    n_bad++; $display("FAIL wrap_seq idx%0d got=%0d exp=%0d", i, got0[i], (2 * i) % NSID);
                end
            end
        end
        n_cmp++;
        if (err_o !== 1'b0) begin
            n_bad++; $display("FAIL wrap_noerr got=%b exp=0", err_o);
        end
        for (int c = 0; c < 2; c++) begin
            drive(0, 3, 2'b01, 8, 64'h33, 0, 0);
            step();
            n_cmp++;
            if (dut_vec() !== exp_vec()) begin
                n_bad++; $display("FAIL wrap_dup_model cyc%0d got=%h exp=%h", c, dut_vec(), exp_vec());
            end
        end
        n_cmp++;
        if (err_o !== 1'b1) begin
            n_bad++; $display("FAIL wrap_dup_err got=%b exp=1", err_o);
        end
    endtask

    task automatic test_errors();
        do_reset();
        for (int c = 0; c < 4; c++) begin
            if (c == 0) begin drive(0, 2, 2'b01, 1, 64'h1, 0, 0); drive(1, 2, 2'b01, 2, 64'h2, 0, 0); end
            if (c == 1) drive(0, 0, 2'b01, 3, 64'h3, 0, 0);
            step();
            n_cmp++;
            if (dut_vec() !== exp_vec()) begin
                n_bad++; $display("FAIL same_sid_model cyc%0d got=%h exp=%h", c, dut_vec(), exp_vec());
            end
        end
        n_cmp++;
        if (err_o !== 1'b1) begin
            n_bad++; $display("FAIL same_sid_err got=%b exp=1", err_o);
        end
        do_reset();
        for (int c = 0; c < 4; c++) begin
            if (c == 0) drive(1, 8, 2'b01, 1, 64'h8, 0, 0);
            if (c == 1) drive(0, 0, 2'b01, 4, 64'h4, 0, 0);
            step();
            n_cmp++;
            if (dut_vec() !== exp_vec()) begin
                n_bad++; $display("FAIL window_model cyc%0d got=%h exp=%h", c, dut_vec(), exp_vec());
            end
        end
        n_cmp++;
        if (err_o !== 1'b1) begin
            n_bad++; $display("FAIL window_err got=%b exp=1", err_o);
        end
    endtask

    task automatic test_endsim();
        bit seen4, seen5;
        seen4 = 0; seen5 = 0;
        do_reset();
        for (int c = 0; c < 8; c++) begin
            if (c == 0) begin drive(0, 0, 2'b01, 1, 64'h0, 0, 0); drive(1, 1, 2'b01, 2, 64'h1, 0, 0); end
            if (c == 1) begin drive(0, 2, 2'b01, 3, 64'h2, 0, 0); drive(1, 3, 2'b01, 4, 64'h3, 0, 0); end
            if (c == 2) begin drive(0, 4, 2'b01, 5, 64'h4, 0, 1); drive(1, 5, 2'b01, 6, 64'h5, 0, 0); end
            step();
            n_cmp++;
            if (dut_vec() !== exp_vec()) begin
                n_bad++; $display("FAIL endsim_model cyc%0d got=%h exp=%h", c, dut_vec(), exp_vec());
            end
            if ((inst0_retire_valid_o && inst0_retire_sid_o == 4'd4) || (inst1_retire_valid_o && inst1_retire_sid_o == 4'd4)) seen4 = 1;
            if ((inst0_retire_valid_o && inst0_retire_sid_o == 4'd5) || (inst1_retire_valid_o && inst1_retire_sid_o == 4'd5)) seen5 = 1;
        end
        n_cmp++;
        if ({seen4, seen5, endsim_o} !== {1'b1, !ENDSIM, ENDSIM}) begin
            n_bad++; $display("FAIL endsim_result got s4=%b s5=%b es=%b exp %b/%b/%b",
                              seen4, seen5, endsim_o, 1'b1, !ENDSIM, ENDSIM);
        end
    endtask

    task automatic test_random();
        int s0, s1;
        bit legal;
        for (int r = 0; r < 4; r++) begin
            legal = (r < 3);
            do_reset();
            for (int c = 0; c < 80; c++) begin
                s0 = -1; s1 = -1;
                if ($urandom_range(0, 9) < 7) begin
                    s0 = (m_head + int'($urandom_range(0, 3))) % NSID;
                    if (legal && m_done[s0]) s0 = -1;
                end
                if ($urandom_range(0, 9) < 5) begin
                    s1 = (m_head + int'($urandom_range(0, 5))) % NSID;
                    if (legal && (m_done[s1] || s1 == s0)) s1 = -1;
                end
                if (s0 >= 0) drive(0, s0, 2'($urandom_range(0, 3)), 5'($urandom), {$urandom, $urandom},
                                   $urandom_range(0, 11) == 0, $urandom_range(0, 39) == 0);
                if (s1 >= 0) drive(1, s1, 2'($urandom_range(0, 3)), 5'($urandom), {$urandom, $urandom},
                                   $urandom_range(0, 11) == 0, $urandom_range(0, 39) == 0);
                step();
                n_cmp++;
                if (dut_vec() !== exp_vec()) begin
                    n_bad++; $display("FAIL random r%0d cyc%0d got=%h exp=%h", r, c, dut_vec(), exp_vec());
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1;
        clear_inputs();
        model_reset();
        test_reset();
        test_single();
        test_out_of_order();
        test_x0_nodest();
        test_flush();
        test_wrap();
        test_errors();
        test_endsim();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
